// File: rtl/wrr_packet_scheduler_pkg.sv
// Shared types and helpers for the weighted round-robin packet scheduler.
package wrr_sched_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int MAX1_W = 16;

    // A zero weight would starve the port, so it is promoted to one packet per turn.
    function automatic logic [MAX1_W-1:0] f_max1(input logic [MAX1_W-1:0] weight);
        return (weight == '0) ? MAX1_W'(1) : weight;
    endfunction

endpackage

// File: rtl/wrr_packet_scheduler_picker.sv
// Circular first-set search over a request vector, starting just after base
// and checking base itself last. Purely combinational.
module rr_priority_picker #(
    parameter  int N_PORTS = 4,
    localparam int IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            w_cand = IDX_W'((int'(base) + i) % N_PORTS);
            if (!found && req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/wrr_packet_scheduler.sv
// Weighted round-robin packet scheduler: holds a grant for a whole packet and
// lets each port send up to its weight in packets before the turn moves on.
module wrr_packet_scheduler
    import wrr_sched_pkg::*;
#(
    parameter  int N_PORTS  = 4,
    parameter  int DATA_W   = 8,
    parameter  int WEIGHT_W = 4,
    localparam int IDX_W    = $clog2(N_PORTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS*DATA_W-1:0]    tdata_i,
    input  logic [N_PORTS-1:0]           tvalid_i,
    input  logic [N_PORTS-1:0]           tlast_i,
    output logic [N_PORTS-1:0]           tready_i,
    output logic [DATA_W-1:0]            tdata_o,
    output logic                         tvalid_o,
    output logic                         tlast_o,
    input  logic                         tready_o,
    input  logic [N_PORTS*WEIGHT_W-1:0]  cfg_weight,
    output logic [IDX_W-1:0]             grant_o,
    output logic                         busy_o
);

    state_t              r_state;
    logic [IDX_W-1:0]    r_cur;
    logic [WEIGHT_W-1:0] r_quota;
    logic                r_busy;

    logic                w_found;
    logic [IDX_W-1:0]    w_next;
    logic [WEIGHT_W-1:0] w_next_weight;
    logic                w_cur_valid;
    logic                w_cur_last;
    logic                w_xfer;

    rr_priority_picker #(
        .N_PORTS (N_PORTS)
    ) u_picker (
        .req   (tvalid_i),
        .base  (r_cur),
        .found (w_found),
        .idx   (w_next)
    );

    assign w_cur_valid   = tvalid_i[r_cur];
    assign w_cur_last    = tlast_i[r_cur];
    assign w_next_weight = cfg_weight[w_next*WEIGHT_W +: WEIGHT_W];
    assign w_xfer        = r_busy && w_cur_valid && tready_o;

    // Quota only decrements in GRANT, where it is always at least one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_quota <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cur_valid && (r_quota != '0)) begin
                        r_state <= ST_GRANT;
                        r_busy  <= 1'b1;
                    end else if (w_found) begin
                        r_cur   <= w_next;
                        r_quota <= WEIGHT_W'(f_max1(MAX1_W'(w_next_weight)));
                        r_state <= ST_GRANT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer && w_cur_last) begin
                        r_quota <= r_quota - WEIGHT_W'(1);
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign grant_o  = r_cur;
    assign tdata_o  = tdata_i[r_cur*DATA_W +: DATA_W];
    assign tvalid_o = r_busy & w_cur_valid;
    assign tlast_o  = r_busy & w_cur_last;

    always_comb begin
        tready_i        = '0;
        tready_i[r_cur] = r_busy & tready_o;
    end

endmodule

// File: tb/tb_wrr_packet_scheduler.sv
// Self-checking bench for wrr_packet_scheduler: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural WRR model.
module tb_wrr_packet_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] tdata_i;
    logic [N-1:0]    tvalid_i;
    logic [N-1:0]    tlast_i;
    logic [N-1:0]    tready_i;
    logic [DW-1:0]   tdata_o;
    logic            tvalid_o;
    logic            tlast_o;
    logic            tready_o;
    logic [N*WW-1:0] cfg_weight;
    logic [1:0]      grant_o;
    logic            busy_o;

    always #5 clk = ~clk;

    wrr_packet_scheduler #(.N_PORTS(N), .DATA_W(DW), .WEIGHT_W(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tdata_i    (tdata_i),
        .tvalid_i   (tvalid_i),
        .tlast_i    (tlast_i),
        .tready_i   (tready_i),
        .tdata_o    (tdata_o),
        .tvalid_o   (tvalid_o),
        .tlast_o    (tlast_o),
        .tready_o   (tready_o),
        .cfg_weight (cfg_weight),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Upstream packet queues: {last, data} per beat.
    logic [8:0]      src_q [N][$];
    logic [N-1:0]    en;
    logic            ds_ready;
    logic [N*WW-1:0] cfg_next;

    // Reference model: turn owner, remaining packets in turn, packet in flight.
    bit m_busy;
    int m_cur;
    int m_quota;

    logic          e_busy, e_vld, e_last;
    logic [N-1:0]  e_ready;
    logic [DW-1:0] e_data;
    logic [1:0]    e_grant;

    int            cyc = 0;
    int            last_tlast_cyc;
    bit            obs_in_pkt;
    int            obs_order[$];
    int            obs_gaps[$];
    logic [DW-1:0] obs_bytes[$];
    int            multi_rdy;
    logic [N-1:0]  rdy_seen;

    task automatic load_pkt(input int p, input int len);
        for (int b = 0; b < len; b++)
            src_q[p].push_back({(b == len - 1), 8'($urandom)});
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int p = 0; p < N; p++) if (src_q[p].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic clear_obs();
        obs_order.delete();
        obs_gaps.delete();
        obs_bytes.delete();
        multi_rdy      = 0;
        rdy_seen       = '0;
        obs_in_pkt     = 1'b0;
        last_tlast_cyc = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        tvalid_i = '0;
        tready_o = 1'b0;
        for (int p = 0; p < N; p++) src_q[p].delete();
        en       = '1;
        ds_ready = 1'b1;
        m_busy   = 1'b0;
        m_cur    = 0;
        m_quota  = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_obs();
    endtask

    // One clock: drive sources, predict outputs with the model, observe egress.
    task automatic step();
        int k;
        int op;
        @(negedge clk);
        cyc++;
        cfg_weight = cfg_next;
        for (int p = 0; p < N; p++) begin
            if (en[p] && src_q[p].size() > 0) begin
                tvalid_i[p]          = 1'b1;
                tdata_i[p*DW +: DW]  = src_q[p][0][7:0];
                tlast_i[p]           = src_q[p][0][8];
            end else begin
                tvalid_i[p]          = 1'b0;
                tdata_i[p*DW +: DW]  = 8'($urandom);
                tlast_i[p]           = 1'($urandom);
            end
        end
        tready_o = ds_ready;

        e_grant = 2'(m_cur);
        if (m_busy) begin
            e_busy         = 1'b1;
            e_ready        = '0;
            e_ready[m_cur] = ds_ready;
            e_vld          = tvalid_i[m_cur];
            e_last         = tlast_i[m_cur];
            e_data         = tdata_i[m_cur*DW +: DW];
            if (e_vld && ds_ready && e_last) begin
                m_quota--;
                m_busy = 1'b0;
            end
        end else begin
            e_busy  = 1'b0;
            e_ready = '0;
            e_vld   = 1'b0;
            e_last  = 1'b0;
            e_data  = '0;
            if (tvalid_i[m_cur] && m_quota != 0) begin
                m_busy = 1'b1;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    k = (m_cur + i) % N;
                    if (!m_busy && tvalid_i[k]) begin
                        m_cur   = k;
                        m_quota = int'(cfg_weight[k*WW +: WW]);
                        if (m_quota == 0) m_quota = 1;
                        m_busy  = 1'b1;
                    end
                end
            end
        end

        #1;
        if (!$onehot0(tready_i)) multi_rdy++;
        rdy_seen |= tready_i;
        if (tvalid_o && tready_o) begin
            op = -1;
            for (int p = 0; p < N; p++) if (tready_i[p]) op = p;
            if (!obs_in_pkt) begin
                obs_order.push_back(op);
                obs_gaps.push_back(cyc - last_tlast_cyc - 1);
            end
            obs_bytes.push_back(tdata_o);
            obs_in_pkt = !tlast_o;
            if (tlast_o) last_tlast_cyc = cyc;
        end
        for (int p = 0; p < N; p++)
            if (tready_i[p] && tvalid_i[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        tvalid_i   = '1;
        tlast_i    = '1;
        tready_o   = 1'b1;
        tdata_i    = 32'($urandom);
        cfg_weight = '1;
        cfg_next   = '1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tready_i !== '0) $display("FAIL reset_tready got=%b exp=0000", tready_i); else n_pass++;
        n_checks++;
        if (tvalid_o !== 1'b0) $display("FAIL reset_tvalid_o got=%b exp=0", tvalid_o); else n_pass++;
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else n_pass++;
        n_checks++;
        if (grant_o !== 2'd0) $display("FAIL reset_grant got=%0d exp=0", grant_o); else n_pass++;
        n_checks++;
        if (tlast_o !== 1'b0) $display("FAIL reset_tlast_o got=%b exp=0", tlast_o); else n_pass++;
    endtask

    task automatic test_rotation();
        int t = 0;
        int bad_gap = 0;
        int got;
        do_reset();
        cfg_next = {4{4'd1}};
        for (int p = 0; p < N; p++) for (int j = 0; j < 4; j++) load_pkt(p, 2);
        while (!all_empty() && t < 400) begin step(); t++; end
        n_checks++;
        if (t >= 400) $display("FAIL rot_timeout got=%0d cycles exp<400", t); else n_pass++;
        // First search after reset starts at port 1 (port 0 is checked last).
        for (int i = 0; i < 16; i++) begin
            got = (i < obs_order.size()) ? obs_order[i] : -1;
            n_checks++;
            if (got !== (1 + i) % 4) $display("FAIL rot_order[%0d] got=%0d exp=%0d", i, got, (1 + i) % 4);
            else n_pass++;
        end
        for (int i = 1; i < obs_gaps.size(); i++) if (obs_gaps[i] != 1) bad_gap++;
        n_checks++;
        if (bad_gap !== 0) $display("FAIL rot_gap got=%0d bad gaps exp=0", bad_gap); else n_pass++;
        n_checks++;
        if (multi_rdy !== 0) $display("FAIL rot_onehot got=%0d violations exp=0", multi_rdy); else n_pass++;
    endtask

    task automatic test_weights();
        int t = 0;
        int got;
        int exp_o[$] = '{1, 2, 3, 0, 0, 0, 1, 2, 3, 0, 0, 0};
        do_reset();
        cfg_next = {4'd1, 4'd0, 4'd1, 4'd3};
        for (int j = 0; j < 6; j++) load_pkt(0, $urandom_range(1, 3));
        for (int p = 1; p < N; p++) for (int j = 0; j < 2; j++) load_pkt(p, $urandom_range(1, 3));
        while (!all_empty() && t < 400) begin step(); t++; end
        n_checks++;
        if (t >= 400) $display("FAIL wgt_timeout got=%0d cycles exp<400", t); else n_pass++;
        n_checks++;
        if (obs_order.size() !== 12) $display("FAIL wgt_count got=%0d exp=12", obs_order.size()); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            got = (i < obs_order.size()) ? obs_order[i] : -1;
            n_checks++;
            if (got !== exp_o[i]) $display("FAIL wgt_order[%0d] got=%0d exp=%0d", i, got, exp_o[i]);
            else n_pass++;
        end
    endtask

    task automatic test_single_port();
        int t = 0;
        int bad_gap = 0;
        int got;
        do_reset();
        cfg_next = {4{4'd1}};
        for (int j = 0; j < 3; j++) load_pkt(2, $urandom_range(1, 4));
        while (!all_empty() && t < 200) begin step(); t++; end
        n_checks++;
        if (obs_order.size() !== 3) $display("FAIL single_count got=%0d exp=3", obs_order.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            got = (i < obs_order.size()) ? obs_order[i] : -1;
            n_checks++;
            if (got !== 2) $display("FAIL single_order[%0d] got=%0d exp=2", i, got); else n_pass++;
        end
        n_checks++;
        if ((rdy_seen & 4'b1011) !== 4'b0000)
            $display("FAIL single_other_ready got=%b exp=0x00", rdy_seen);
        else n_pass++;
        for (int i = 1; i < obs_gaps.size(); i++) if (obs_gaps[i] != 1) bad_gap++;
        n_checks++;
        if (bad_gap !== 0) $display("FAIL single_gap got=%0d bad gaps exp=0", bad_gap); else n_pass++;
    endtask

    task automatic test_backpressure();
        int t = 0;
        logic [DW-1:0] exp_b[$];
        do_reset();
        cfg_next = {4{4'd1}};
        load_pkt(1, 5);
        for (int i = 0; i < 5; i++) exp_b.push_back(src_q[1][i][7:0]);
        load_pkt(0, 2);
        en = 4'b0010;
        while (!all_empty() && t < 300) begin
            ds_ready = (t % 2 == 0);
            if (obs_bytes.size() >= 2) en[0] = 1'b1;
            en[1] = ($urandom_range(0, 3) != 0);
            step();
            t++;
            n_checks++;
            if ({busy_o, tvalid_o, tready_i, grant_o} !== {e_busy, e_vld, e_ready, e_grant})
                $display("FAIL bp_ctrl cyc=%0d got busy=%b vld=%b rdy=%b grant=%0d exp busy=%b vld=%b rdy=%b grant=%0d",
                         cyc, busy_o, tvalid_o, tready_i, grant_o, e_busy, e_vld, e_ready, e_grant);
            else n_pass++;
        end
        n_checks++;
        if (t >= 300) $display("FAIL bp_timeout got=%0d cycles exp<300", t); else n_pass++;
        n_checks++;
        if (obs_order.size() !== 2 || obs_order[0] !== 1 || obs_order[1] !== 0)
            $display("FAIL bp_order got size=%0d first=%0d exp 1 then 0", obs_order.size(),
                     (obs_order.size() > 0) ? obs_order[0] : -1);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= obs_bytes.size() || obs_bytes[i] !== exp_b[i])
                $display("FAIL bp_byte[%0d] got=%h exp=%h", i,
                         (i < obs_bytes.size()) ? obs_bytes[i] : 8'hxx, exp_b[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_packet();
        int t = 0;
        do_reset();
        cfg_next = {4{4'd1}};
        load_pkt(3, 6);
        load_pkt(1, 2);
        en = 4'b1000;
        while (obs_bytes.size() < 2 && t < 50) begin step(); t++; end
        n_checks++;
        if (obs_order.size() < 1 || obs_order[0] !== 3)
            $display("FAIL mid_first got=%0d exp=3", (obs_order.size() > 0) ? obs_order[0] : -1);
        else n_pass++;
        // Third beat is on the bus now; reset lands before it can transfer.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({tvalid_o, tready_i, busy_o, grant_o} !== {1'b0, 4'b0000, 1'b0, 2'd0})
            $display("FAIL mid_reset_idle got vld=%b rdy=%b busy=%b grant=%0d exp all 0",
                     tvalid_o, tready_i, busy_o, grant_o);
        else n_pass++;
        @(negedge clk);
        src_q[3].delete();
        load_pkt(3, 2);
        m_busy   = 1'b0;
        m_cur    = 0;
        m_quota  = 0;
        en       = '1;
        tvalid_i = '0;
        rst      = 1'b0;
        clear_obs();
        t = 0;
        while (!all_empty() && t < 100) begin step(); t++; end
        n_checks++;
        if (obs_order.size() !== 2 || obs_order[0] !== 1 || obs_order[1] !== 3)
            $display("FAIL mid_restart got size=%0d first=%0d exp 1 then 3", obs_order.size(),
                     (obs_order.size() > 0) ? obs_order[0] : -1);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        cfg_next = 16'($urandom);
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < N; p++) begin
                en[p] = ($urandom_range(0, 9) != 0);
                if (src_q[p].size() == 0 && $urandom_range(0, 2) == 0) load_pkt(p, $urandom_range(1, 5));
            end
            ds_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) cfg_next = 16'($urandom);
            step();
            n_checks++;
            if ({busy_o, tvalid_o, tready_i, grant_o} !== {e_busy, e_vld, e_ready, e_grant})
                $display("FAIL rnd_ctrl cyc=%0d got busy=%b vld=%b rdy=%b grant=%0d exp busy=%b vld=%b rdy=%b grant=%0d",
                         cyc, busy_o, tvalid_o, tready_i, grant_o, e_busy, e_vld, e_ready, e_grant);
            else n_pass++;
            if (e_busy) begin
                n_checks++;
                if ({tlast_o, tdata_o} !== {e_last, e_data})
                    $display("FAIL rnd_data cyc=%0d got last=%b data=%h exp last=%b data=%h",
                             cyc, tlast_o, tdata_o, e_last, e_data);
                else n_pass++;
            end
        end
        n_checks++;
        if (multi_rdy !== 0) $display("FAIL rnd_onehot got=%0d violations exp=0", multi_rdy); else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        en       = '1;
        ds_ready = 1'b1;
        test_reset();
        test_rotation();
        test_weights();
        test_single_port();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
